spi_cmd_ctrl: RTL and testbench

//  Command sequencer between the SPI slave front-end and the register/arith datapath.

---
 rtl/spi_cmd_ctrl.sv | 149 ++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer between the SPI slave front-end and the register/sum datapath.
// Decodes command bytes, arms writes, multi-cycle sums and read-backs, and loads the tx shift register.
//
// state  | meaning
// IDLE   | waiting for a command byte
// WR_ARM | write armed, next data word goes to reg[idx]
// SUM    | accumulating reg[cnt] one register per cycle
// RD_ARM | txbuf holds a word, waiting for the master to open a read frame
module spi_cmd_ctrl #(
  parameter int CMD_W   = 8,
  parameter int DATA_W  = 16,
  parameter int NREG    = 3,
  parameter int CMD_SUM = 128,
  parameter int CMD_RDB = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_vld,
  input  logic [CMD_W-1:0]       cmd_byte,
  input  logic                   wr_vld,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_req,
  output logic                   tx_load,
  output logic [DATA_W-1:0]      tx_data,
  output logic [NREG*DATA_W-1:0] regs_q,
  output logic                   busy,
  output logic                   err
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {IDLE, WR_ARM, SUM, RD_ARM} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] acc, txbuf;
  logic [IDX_W-1:0]  idx, cnt;
  logic              pend;

  logic              dec_wr, dec_sum, dec_rdb, dec_bad, do_dec;
  logic [IDX_W-1:0]  wr_idx, rdb_idx;
  logic [DATA_W-1:0] sum_val, rdb_val, tx_word;
  logic              sum_last, wr_en, tx_fire, err_nxt;

  function automatic logic [DATA_W-1:0] reg_sel(input logic [IDX_W-1:0] i);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < NREG; k++)
      if (i == IDX_W'(k)) v = regs[k];
    return v;
  endfunction

  always_comb begin
    dec_wr  = (cmd_byte >= CMD_W'(1)) && (cmd_byte <= CMD_W'(NREG));
    dec_sum = (cmd_byte == CMD_W'(CMD_SUM));
    dec_rdb = (cmd_byte >= CMD_W'(CMD_RDB)) && (cmd_byte < CMD_W'(CMD_RDB + NREG));
    dec_bad = !(dec_wr || dec_sum || dec_rdb);
    wr_idx  = IDX_W'(cmd_byte - CMD_W'(1));
    rdb_idx = IDX_W'(cmd_byte - CMD_W'(CMD_RDB));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the sum cannot be interrupted by a command
  always_comb begin
    state_nxt = state;
    do_dec    = cmd_vld && (state != SUM);
    sum_last  = (cnt == IDX_W'(NREG - 1));
    case (state)
      IDLE:   ;
      WR_ARM: if (wr_vld) state_nxt = IDLE;
      SUM:    if (sum_last) state_nxt = (pend || rd_req) ? IDLE : RD_ARM;
      RD_ARM: if (rd_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (do_dec) begin
      if (dec_wr)       state_nxt = WR_ARM;
      else if (dec_sum) state_nxt = SUM;
      else if (dec_rdb) state_nxt = RD_ARM;
      else              state_nxt = IDLE;
    end
  end

  // Output and datapath control
  always_comb begin
    wr_en   = wr_vld && (state == WR_ARM);
    sum_val = acc + reg_sel(cnt);
    // A read-back decoded alongside a committing write to the same reg sees the new word
    rdb_val = (wr_en && (idx == rdb_idx)) ? wr_data : reg_sel(rdb_idx);
    tx_fire = ((state == RD_ARM) && rd_req) ||
              ((state == SUM) && sum_last && (pend || rd_req));
    tx_word = (state == SUM) ? sum_val : txbuf;
    err_nxt = (do_dec && dec_bad) ||
              ((state == IDLE)   && (wr_vld || rd_req)) ||
              ((state == WR_ARM) && rd_req) ||
              ((state == SUM)    && (cmd_vld || wr_vld)) ||
              ((state == RD_ARM) && wr_vld);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
      acc     <= '0;
      txbuf   <= '0;
      idx     <= '0;
      cnt     <= '0;
      pend    <= 1'b0;
      tx_load <= 1'b0;
      tx_data <= '0;
      err     <= 1'b0;
    end else begin
      tx_load <= tx_fire;
      err     <= err_nxt;
      if (tx_fire) tx_data <= tx_word;
      if (wr_en)
        for (int k = 0; k < NREG; k++)
          if (idx == IDX_W'(k)) regs[k] <= wr_data;
      if (state == SUM) begin
        acc <= sum_val;
        cnt <= cnt + IDX_W'(1);
        if (sum_last) begin
          txbuf <= sum_val;
          pend  <= 1'b0;
        end else if (rd_req) begin
          pend <= 1'b1;
        end
      end
      if (do_dec) begin
        if (dec_wr) idx <= wr_idx;
        if (dec_sum) begin
          acc <= '0;
          cnt <= '0;
        end
        if (dec_rdb) txbuf <= rdb_val;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NREG; k++) regs_q[k*DATA_W +: DATA_W] = regs[k];
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed command sequences against a transaction-level model,
// with a per-cycle compare process and a few hand-computed expectations.
module tb_spi_cmd_ctrl;

  logic        clk, rst;
  logic        cmd_vld, wr_vld, rd_req;
  logic [7:0]  cmd_byte;
  logic [15:0] wr_data;
  logic        tx_load, busy, err;
  logic [15:0] tx_data;
  logic [47:0] regs_q;

  spi_cmd_ctrl dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_byte(cmd_byte),
    .wr_vld(wr_vld), .wr_data(wr_data), .rd_req(rd_req),
    .tx_load(tx_load), .tx_data(tx_data), .regs_q(regs_q),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_txl = 0;
  int n_errp = 0;
  logic chk_en = 1'b0;

  // Model: 0 idle, 1 write armed, 2 summing, 3 read armed
  int          m_mode, m_idx, m_left;
  logic        m_pend;
  logic [15:0] m_val;
  logic [15:0] m_regs [3];
  logic        exp_tx_load, exp_err, exp_busy;
  logic [15:0] exp_tx_data;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_idx = 0; m_left = 0; m_pend = 1'b0; m_val = '0;
    for (int k = 0; k < 3; k++) m_regs[k] = '0;
    exp_tx_load = 1'b0; exp_err = 1'b0; exp_busy = 1'b0; exp_tx_data = '0;
  endtask

  task automatic m_step();
    logic dec;
    int   c;
    int   s;
    dec = 1'b0;
    exp_tx_load = 1'b0;
    exp_err = 1'b0;
    case (m_mode)
      0: begin
        if (wr_vld || rd_req) exp_err = 1'b1;
        dec = cmd_vld;
      end
      1: begin
        if (wr_vld) begin m_regs[m_idx] = wr_data; m_mode = 0; end
        if (rd_req) exp_err = 1'b1;
        dec = cmd_vld;
      end
      2: begin
        if (cmd_vld || wr_vld) exp_err = 1'b1;
        if (rd_req) m_pend = 1'b1;
        m_left--;
        if (m_left == 0) begin
          if (m_pend) begin
            exp_tx_load = 1'b1; exp_tx_data = m_val; m_mode = 0; m_pend = 1'b0;
          end else m_mode = 3;
        end
      end
      default: begin
        if (wr_vld) exp_err = 1'b1;
        if (rd_req) begin exp_tx_load = 1'b1; exp_tx_data = m_val; m_mode = 0; end
        dec = cmd_vld;
      end
    endcase
    if (dec) begin
      c = int'(cmd_byte);
      if (c >= 1 && c <= 3) begin
        m_mode = 1; m_idx = c - 1;
      end else if (c == 128) begin
        s = m_regs[0] + m_regs[1] + m_regs[2];
        m_val = 16'(s); m_mode = 2; m_left = 3; m_pend = 1'b0;
      end else if (c >= 64 && c < 67) begin
        m_mode = 3; m_val = m_regs[c - 64];
      end else begin
        m_mode = 0; exp_err = 1'b1;
      end
    end
    exp_busy = (m_mode != 0);
  endtask

  always @(negedge clk) begin
    if (tx_load) n_txl++;
    if (err) n_errp++;
    if (chk_en) begin
      chk("tx_load", 48'(tx_load), 48'(exp_tx_load));
      chk("tx_data", 48'(tx_data), 48'(exp_tx_data));
      chk("err",     48'(err),     48'(exp_err));
      chk("busy",    48'(busy),    48'(exp_busy));
      chk("regs_q",  regs_q, {m_regs[2], m_regs[1], m_regs[0]});
    end
  end

  task automatic step(input logic cv, input logic [7:0] cb, input logic wv,
                      input logic [15:0] wd, input logic rr);
    cmd_vld = cv; cmd_byte = cb; wr_vld = wv; wr_data = wd; rd_req = rr;
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);  step(1'b1, c, 1'b0, 16'h0, 1'b0); endtask
  task automatic send_wr(input logic [15:0] d);  step(1'b0, 8'h0, 1'b1, d, 1'b0); endtask
  task automatic send_rd();                      step(1'b0, 8'h0, 1'b0, 16'h0, 1'b1); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h0, 1'b0, 16'h0, 1'b0);
  endtask

  int txl0, errp0;

  initial begin
    cmd_vld = 0; cmd_byte = 0; wr_vld = 0; wr_data = 0; rd_req = 0;
    rst = 1'b1;
    m_reset();
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_tx_data", 48'(tx_data), 48'h0);
    chk("reset_busy", 48'(busy), 48'h0);

    // Reset in the middle of a sum
    send_cmd(8'd1); send_wr(16'h00AA);
    send_cmd(8'd128); idle(1);
    #2 rst = 1'b1;
    m_reset();
    #1;
    chk("rst_async_regs", regs_q, 48'h0);
    chk("rst_async_busy", 48'(busy), 48'h0);
    @(negedge clk);
    rst = 1'b0;
    txl0 = n_txl;
    idle(6);
    chk("rst_no_tx_load", 48'(n_txl - txl0), 48'h0);

    // Write three regs, then sum and read
    send_cmd(8'd1); send_wr(16'h1234);
    send_cmd(8'd2); send_wr(16'h0101);
    send_cmd(8'd3); send_wr(16'h0011);
    txl0 = n_txl;
    send_cmd(8'd128); idle(3); send_rd();
    chk("sum_tx_data", 48'(tx_data), 48'h1346);
    idle(2);
    chk("sum_tx_once", 48'(n_txl - txl0), 48'h1);

    // Wrap-around
    errp0 = n_errp;
    send_cmd(8'd1); send_wr(16'hFFFF);
    send_cmd(8'd2); send_wr(16'h0002);
    send_cmd(8'd3); send_wr(16'h0000);
    send_cmd(8'd128); idle(3); send_rd();
    chk("wrap_tx_data", 48'(tx_data), 48'h0001);
    idle(1);
    chk("wrap_no_err", 48'(n_errp - errp0), 48'h0);

    // Early read during SUM
    send_cmd(8'd3); send_wr(16'h0100);
    send_cmd(8'd128); send_rd(); idle(1);
    chk("early_not_yet", 48'(tx_load), 48'h0);
    idle(1);
    chk("early_tx_load", 48'(tx_load), 48'h1);
    chk("early_tx_data", 48'(tx_data), 48'h0101);
    idle(2);

    // Supersede before the data word, then cmd and data in the same cycle
    send_cmd(8'd2); send_cmd(8'd3); send_wr(16'hBEEF);
    chk("sup_reg2", 48'(regs_q[32 +: 16]), 48'hBEEF);
    chk("sup_reg1", 48'(regs_q[16 +: 16]), 48'h0002);
    send_cmd(8'd1);
    step(1'b1, 8'd3, 1'b1, 16'h5555, 1'b0);
    chk("same_old_idx", 48'(regs_q[0 +: 16]), 48'h5555);
    send_wr(16'h7777);
    chk("same_new_idx", 48'(regs_q[32 +: 16]), 48'h7777);

    // Protocol errors and read-back
    send_cmd(8'h07);
    chk("bad_cmd_err", 48'(err), 48'h1);
    send_cmd(8'h00);
    chk("zero_cmd_err", 48'(err), 48'h1);
    send_rd();
    chk("idle_rd_err", 48'(err), 48'h1);
    chk("idle_rd_no_load", 48'(tx_load), 48'h0);
    send_cmd(8'd65); send_rd();
    chk("rdb_tx_data", 48'(tx_data), 48'h0002);
    send_cmd(8'd64); send_wr(16'h1111);
    chk("rdarm_wr_err", 48'(err), 48'h1);
    send_rd();
    chk("rdb0_tx_data", 48'(tx_data), 48'h5555);
    idle(3);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
